// File: rtl/hdmi_buf_pkg.sv
// hdmi_buf_pkg: shared constants and types for the HDMI ping-pong bank scheduler.
//   DEF_BANK_DEPTH / DEF_ADDR_W : default bank size and in-bank address width
//   RGB565 field widths and the resulting pixel width
//   sched_state_t               : top scheduler FSM states
package hdmi_buf_pkg;

    localparam int DEF_BANK_DEPTH = 7040;
    localparam int DEF_ADDR_W     = 13;

    localparam int RGB_R_W = 5;
    localparam int RGB_G_W = 6;
    localparam int RGB_B_W = 5;
    localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pp_bank_flags.sv
// pp_bank_flags: the two per-bank "full" bits shared by writer and reader.
//   clk, rst            : clock, synchronous active-high reset
//   set_en, set_bank    : writer stored the last pixel of set_bank
//   clr_en, clr_bank    : reader consumed the last pixel of clr_bank
//   full                : registered full flags
//   full_avail          : full flags with this cycle's release already applied,
//                         so the writer can swap into a bank freed this cycle
module pp_bank_flags (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic       set_bank,
    input  logic       clr_en,
    input  logic       clr_bank,
    output logic [1:0] full,
    output logic [1:0] full_avail
);

    logic [1:0] set_mask;
    logic [1:0] clr_mask;

    always_comb begin
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (set_en) set_mask[set_bank] = 1'b1;
        if (clr_en) clr_mask[clr_bank] = 1'b1;
    end

    assign full_avail = full & ~clr_mask;

    always_ff @(posedge clk) begin
        if (rst) full <= 2'b00;
        else     full <= (full & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/hdmi_pingpong_sched.sv
// hdmi_pingpong_sched: steers camera pixels into one of two RGB565 banks while
// the HDMI side drains the other, swapping banks as each one completes.
// Optional status logic (overrun/underrun/drop_count) is built only when the
// macro HDMI_SCHED_STATUS_EN is defined; otherwise those outputs read 0.
//   cam_sof/cam_valid/cam_pixel : camera stream (no backpressure)
//   wr_en/wr_bank/wr_addr/wr_data : registered RAM write port
//   rd_en                       : HDMI pixel request
//   rd_bank/rd_addr/rd_valid    : read pointer and served-request qualifier
//   BUFFER_EN                   : sticky, first bank filled
//   overrun/underrun/drop_count : sticky status and saturating drop counter
module hdmi_pingpong_sched
    import hdmi_buf_pkg::*;
#(
    parameter int BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_sof,
    input  logic              cam_valid,
    input  logic [PIX_W-1:0]  cam_pixel,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              BUFFER_EN,
    output logic              overrun,
    output logic              underrun,
    output logic [15:0]       drop_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);

    sched_state_t      state;
    logic              cur_bank;   // bank the writer is currently filling
    logic [ADDR_W-1:0] wr_ptr;     // next write address in cur_bank
    logic              stall;      // both banks full, dropping until one frees
    logic [1:0]        full;
    logic [1:0]        full_avail;

    logic              wr_active;
    logic [ADDR_W-1:0] wr_slot;
    logic              accept;
    logic              wr_last;
    logic              rd_hit;
    logic              rd_last;
    logic              other_free;

    assign wr_active  = (state != IDLE);
    // A start-of-frame restarts the line, so a pixel arriving with it lands at 0.
    assign wr_slot    = cam_sof ? '0 : wr_ptr;
    assign accept     = wr_active & cam_valid & ~stall & ~full[cur_bank];
    assign wr_last    = accept & (wr_slot == LAST_ADDR);
    assign rd_hit     = rd_en & full[rd_bank];
    assign rd_last    = rd_hit & (rd_addr == LAST_ADDR);
    assign other_free = ~full_avail[~cur_bank];

    pp_bank_flags u_flags (
        .clk        (clk),
        .rst        (rst),
        .set_en     (wr_last),
        .set_bank   (cur_bank),
        .clr_en     (rd_last),
        .clr_bank   (rd_bank),
        .full       (full),
        .full_avail (full_avail)
    );

    // Write side: FSM, bank steering and registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_bank  <= 1'b0;
            wr_ptr    <= '0;
            stall     <= 1'b0;
            wr_en     <= 1'b0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            BUFFER_EN <= 1'b0;
        end else begin
            wr_en     <= accept;
            wr_bank   <= cur_bank;
            BUFFER_EN <= BUFFER_EN | (state == RUN);
            if (accept) begin
                wr_addr <= wr_slot;
                wr_data <= cam_pixel;
            end
            case (state)
                IDLE: begin
                    if (cam_sof) begin
                        state  <= FILL;
                        wr_ptr <= '0;
                    end
                end
                FILL, RUN: begin
                    if (stall) begin
                        // wr_ptr is already 0 from the completion that stalled us.
                        if (other_free) begin
                            cur_bank <= ~cur_bank;
                            stall    <= 1'b0;
                        end
                    end else if (accept) begin
                        if (wr_slot == LAST_ADDR) begin
                            wr_ptr <= '0;
                            if (state == FILL) state <= RUN;
                            if (other_free) cur_bank <= ~cur_bank;
                            else            stall    <= 1'b1;
                        end else begin
                            wr_ptr <= wr_slot + ADDR_W'(1);
                        end
                    end else if (cam_sof) begin
                        wr_ptr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read side: pointer advances only on served requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank  <= 1'b0;
            rd_addr  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                if (rd_last) begin
                    rd_addr <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef HDMI_SCHED_STATUS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic drop;
    assign drop = wr_active & cam_valid & ~accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun    <= 1'b0;
            underrun   <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            if (drop) begin
                overrun    <= 1'b1;
                drop_count <= sat_inc16(drop_count);
            end
            if (rd_en & ~full[rd_bank]) underrun <= 1'b1;
        end
    end
`else
    assign overrun    = 1'b0;
    assign underrun   = 1'b0;
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_hdmi_pingpong_sched.sv
module tb_hdmi_pingpong_sched;

    localparam int D  = 16;
    localparam int AW = 4;
`ifdef HDMI_SCHED_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cam_sof = 1'b0;
    logic          cam_valid = 1'b0;
    logic [15:0]   cam_pixel = 16'd0;
    logic          rd_en = 1'b0;
    logic          wr_en, wr_bank, rd_bank, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [15:0]   wr_data, drop_count;
    logic          BUFFER_EN, overrun, underrun;

    hdmi_pingpong_sched #(.BANK_DEPTH(D), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .cam_sof(cam_sof), .cam_valid(cam_valid),
        .cam_pixel(cam_pixel), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .BUFFER_EN(BUFFER_EN), .overrun(overrun), .underrun(underrun),
        .drop_count(drop_count)
    );

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_exp_t;

    wr_exp_t wq[$];
    logic    rq[$];
    int      n_total = 0;
    int      n_bad   = 0;

    // Reference model state
    int       m_state;
    logic     m_cur, m_stall, m_rbank, m_bufen, m_over, m_under, m_wbo;
    int       m_ptr, m_raddr, m_drops;
    logic [1:0] m_full;
    bit       mon_en = 1'b0;
    wr_exp_t  mon_e;
    logic     mon_r;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_drop();
        m_over = 1'b1;
        if (m_drops < 65535) m_drops++;
    endtask

    task automatic model_step(input logic r, input logic s, input logic v,
                              input logic [15:0] p, input logic rd);
        int slot;
        if (r) begin
            m_state = 0; m_cur = 0; m_ptr = 0; m_stall = 0; m_full = 2'b00;
            m_rbank = 0; m_raddr = 0; m_bufen = 0; m_over = 0; m_under = 0;
            m_drops = 0; m_wbo = 0;
            wq.delete(); rq.delete();
            return;
        end
        m_wbo   = m_cur;
        m_bufen = m_bufen | (m_state == 2);
        // reader first: a release is visible to this cycle's write decision
        if (rd) begin
            if (m_full[m_rbank]) begin
                rq.push_back(1'b1);
                if (m_raddr == D - 1) begin
                    m_full[m_rbank] = 1'b0;
                    m_rbank = ~m_rbank;
                    m_raddr = 0;
                end else m_raddr++;
            end else begin
                rq.push_back(1'b0);
                m_under = 1'b1;
            end
        end
        if (m_state == 0) begin
            if (s) begin m_state = 1; m_ptr = 0; end
        end else if (m_stall) begin
            if (v) model_drop();
            if (!m_full[~m_cur]) begin m_cur = ~m_cur; m_ptr = 0; m_stall = 0; end
        end else begin
            slot = s ? 0 : m_ptr;
            if (v && m_full[m_cur]) model_drop();
            else if (v) begin
                wq.push_back({m_cur, AW'(slot), p});
                if (slot == D - 1) begin
                    m_full[m_cur] = 1'b1;
                    m_ptr = 0;
                    if (m_state == 1) m_state = 2;
                    if (m_full[~m_cur]) m_stall = 1'b1;
                    else                m_cur = ~m_cur;
                end else m_ptr = slot + 1;
            end else if (s) m_ptr = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic v,
                         input logic [15:0] p, input logic rd);
        rst = r; cam_sof = s; cam_valid = v; cam_pixel = p; rd_en = rd;
        @(posedge clk);
        model_step(r, s, v, p, rd);
        #1;
        rst = 1'b0; cam_sof = 1'b0; cam_valid = 1'b0; cam_pixel = 16'd0; rd_en = 1'b0;
    endtask

    // Scoreboard and per-cycle state monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (wq.size() > 0) begin
                mon_e = wq.pop_front();
                check_val("wr_en", wr_en, 1);
                check_val("wr_bank_w", wr_bank, mon_e.bank);
                check_val("wr_addr", wr_addr, mon_e.addr);
                check_val("wr_data", wr_data, mon_e.data);
            end else begin
                check_val("wr_en_idle", wr_en, 0);
            end
            if (rq.size() > 0) begin
                mon_r = rq.pop_front();
                check_val("rd_valid", rd_valid, mon_r);
            end else begin
                check_val("rd_valid_idle", rd_valid, 0);
            end
            check_val("wr_bank", wr_bank, m_wbo);
            check_val("rd_bank", rd_bank, m_rbank);
            check_val("rd_addr", rd_addr, m_raddr);
            check_val("buffer_en", BUFFER_EN, m_bufen);
            check_val("overrun", overrun, STAT ? m_over : 1'b0);
            check_val("underrun", underrun, STAT ? m_under : 1'b0);
            check_val("drop_count", drop_count, STAT ? m_drops : 0);
        end
    end

    initial begin
        cycle(1, 0, 0, 0, 0);
        mon_en = 1'b1;
        cycle(1, 0, 0, 0, 0);

        // Read before any bank is full
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check_val("early_rd_valid", rd_valid, 0);
        check_val("early_rd_addr", rd_addr, 0);
        check_val("early_underrun", underrun, STAT ? 1 : 0);
        check_val("early_buffer_en", BUFFER_EN, 0);

        // First fill of bank 0
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < D; i++) cycle(0, 0, 1, 16'($urandom), 0);
        check_val("fill_last_addr", wr_addr, D - 1);
        check_val("fill_last_bank", wr_bank, 0);
        check_val("fill_bufen_early", BUFFER_EN, 0);
        check_val("fill_full", u_dut.full, 2'b01);
        cycle(0, 0, 0, 0, 0);
        check_val("fill_bufen", BUFFER_EN, 1);
        check_val("fill_wr_bank", wr_bank, 1);

        // Steady state; first bank boundary has write completion and read release together
        for (int i = 0; i < D; i++) cycle(0, 0, 1, 16'($urandom), 1);
        check_val("swap_full", u_dut.full, 2'b10);
        cycle(0, 0, 1, 16'($urandom), 1);
        check_val("swap_wr_bank", wr_bank, 0);
        check_val("swap_wr_addr", wr_addr, 0);
        for (int i = 0; i < 3 * D - 1; i++) cycle(0, 0, 1, 16'($urandom), 1);
        check_val("steady_overrun", overrun, 0);
        check_val("steady_underrun", underrun, 0);

        // Overrun: 40 pixels with no reader
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(0, 0, 1, 16'($urandom), 0);
        check_val("ovr_full", u_dut.full, 2'b11);
        check_val("ovr_drops", drop_count, STAT ? 8 : 0);
        check_val("ovr_flag", overrun, STAT ? 1 : 0);
        for (int i = 0; i < D; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 16'h5A5A, 0);
        check_val("resume_wr_en", wr_en, 1);
        check_val("resume_bank", wr_bank, 0);
        check_val("resume_addr", wr_addr, 0);

        // Start-of-frame mid bank 1, then reset mid-run
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < D + 5; i++) cycle(0, 0, 1, 16'($urandom), 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 16'hA5A5, 0);
        check_val("sof_bank", wr_bank, 1);
        check_val("sof_addr", wr_addr, 0);
        check_val("sof_full", u_dut.full, 2'b01);
        cycle(1, 0, 1, 16'h1234, 1);
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_bufen", BUFFER_EN, 0);
        check_val("rst_full", u_dut.full, 2'b00);
        cycle(0, 0, 1, 16'h4321, 0);
        check_val("rst_need_sof", wr_en, 0);

        // Random traffic
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            cycle(0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
                  16'($urandom), 1'($urandom_range(0, 1)));
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_val("wq_left", wq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hdmi_pingpong_sched.md
# hdmi_pingpong_sched

- Ping-pong bank scheduler between the camera pixel stream and the HDMI RGB timing generator.
- Owns a two-bank RGB565 pixel buffer:
  - steers camera writes into one bank while the HDMI side drains the other;
  - swaps banks on completion;
  - raises BUFFER_EN once the first bank is full, which gates the start of HDMI timing.
- Sits between the camera capture logic and the buffer RAM / HDMI_RGB_VPG read port.

## Interface
Parameters:
- BANK_DEPTH, 7040: pixels per bank.
- ADDR_W, 13: address width; must satisfy 2^ADDR_W ≥ BANK_DEPTH.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cam_sof  in  1  camera start-of-frame pulse.
- cam_valid  in  1  camera pixel qualifier; no backpressure.
- cam_pixel  in  16  RGB565 pixel.
- wr_en  out  1  RAM write strobe.
- wr_bank  out  1  bank being written.
- wr_addr  out  ADDR_W  write address within the bank.
- wr_data  out  16  registered cam_pixel.
- rd_en  in  1  HDMI pixel request (pre-DE).
- rd_bank  out  1  bank being read.
- rd_addr  out  ADDR_W  read address within the bank.
- rd_valid  out  1  high when the request was served from a full bank.
- BUFFER_EN  out  1  first bank filled; sticky until reset.
- overrun  out  1  sticky; camera pixel dropped.
- underrun  out  1  sticky; read requested from a non-full bank.
- drop_count  out  16  saturating count of dropped pixels.

## Operation
- Top FSM states:
  - IDLE: ignore camera; wait for cam_sof.
  - FILL: writing bank 0; no bank full yet.
  - RUN: normal ping-pong operation.
- FSM transitions:
  - IDLE→FILL on cam_sof.
  - FILL→RUN when bank 0 completes.
- Per-bank flag full[1:0]:
  - set when the writer stores pixel BANK_DEPTH-1;
  - cleared when the reader consumes pixel BANK_DEPTH-1.
- Write path, in FILL/RUN:
  - cam_valid with full[wr_bank]=0 → wr_en=1, wr_addr increments.
  - At the last address, set full[wr_bank]. If the other bank is not full, toggle wr_bank and reset wr_addr to 0. Otherwise enter STALL: drop pixels until the other bank frees, then swap.
- Dropped pixel (cam_valid in STALL, or while full[wr_bank]=1):
  - wr_en=0;
  - overrun set;
  - drop_count increments, saturating at 0xFFFF.
- cam_sof in FILL/RUN: wr_addr←0 in the current wr_bank; the partial line is discarded. full flags are unchanged.
- Read path:
  - rd_en with full[rd_bank]=1 → rd_valid=1, rd_addr increments.
  - At the last address, clear full[rd_bank], toggle rd_bank, rd_addr←0.
  - rd_en with full[rd_bank]=0 → rd_valid=0, rd_addr holds, underrun set.
- Simultaneous events: a read-side release takes effect before the write-side swap decision in the same cycle. If the writer completes a bank while the reader frees the other bank, the writer swaps with no drop.
- A write completion and a read of the same bank cannot coincide, because the reader only reads full banks.
- BUFFER_EN rises on FILL→RUN and never falls except on reset.

## Timing
- Reset values:
  - FSM=IDLE;
  - wr_en=0, wr_bank=0, wr_addr=0, wr_data=0;
  - rd_bank=0, rd_addr=0, rd_valid=0;
  - full=00;
  - BUFFER_EN=0, overrun=0, underrun=0, drop_count=0.
- Reset mid-operation clears everything in the same cycle. The first cam_sof after reset is required to restart.
- Write latency: cam_valid/cam_pixel at cycle n → wr_en/wr_addr/wr_data valid at cycle n+1.
- Read: rd_addr is registered and advances the cycle after rd_en. rd_valid is registered and aligned with the RAM's one-cycle synchronous read data.
- full updates are visible to the opposite side on the next cycle, except for the same-cycle release rule above.
- BUFFER_EN is asserted one cycle after the write of pixel BANK_DEPTH-1 of bank 0.

## Configuration
- Macro: HDMI_SCHED_STATUS_EN.
- Defined: overrun, underrun and drop_count are implemented as described.
- Undefined:
  - the three outputs are tied to 0 and their registers are removed;
  - pixel dropping and underrun hold behaviour are unchanged.

## Structure
- Package hdmi_buf_pkg holds:
  - the default BANK_DEPTH and ADDR_W constants;
  - the FSM state typedef (IDLE, FILL, RUN);
  - the RGB565 field widths.
- One sub-module, pp_bank_flags: the two full bits plus the set/clear/same-cycle-release resolution, shared by both sides.

## Test plan
All scenarios use BANK_DEPTH=16.
- Reset then cam_sof, 16 consecutive cam_valid → wr_addr 0..15 on bank 0, then wr_bank=1, full=01, BUFFER_EN=1 one cycle after the 16th write.
- Steady state, rd_en continuous at the same rate as cam_valid → banks alternate every 16 pixels, rd_valid=1 throughout, overrun=0, underrun=0.
- 40 cam_valid with no rd_en → banks 0 and 1 full after 32; pixels 33..40 dropped, overrun=1, drop_count=8. Then 16 rd_en → bank 0 freed and writes resume at bank 0 addr 0.
- Writer completes bank 1 in the same cycle the reader consumes bank 0 addr 15 → wr_bank→0 with no drop, full=10.
- rd_en asserted before BUFFER_EN → rd_valid=0, rd_addr stays 0, underrun=1.
- cam_sof after 5 writes into bank 1 → wr_addr returns to 0 in bank 1; the full flags are unchanged. Also, rst asserted mid-RUN → all outputs at reset values next cycle.
